// File: rtl/pic_host_driver.sv
// Host-side bus master for an 8259-style interrupt controller: ICW init sequence, OCW writes,
// status reads and the two-pulse INTA cycle. Define PIC_HOST_INTA_EN to build the acknowledge path.

module pic_host_driver #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       ocw_req,
    input  logic       ocw_a0,
    input  logic [7:0] ocw_data,
    input  logic       rd_req,
    input  logic       int_in,
    input  logic [7:0] data_in,
    output logic       wr_n,
    output logic       rd_n,
    output logic       inta_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       init_done,
    output logic       ocw_done,
    output logic       rd_valid,
    output logic       vector_valid,
    output logic [7:0] rd_data,
    output logic [7:0] vector
);

    localparam int CW = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_W_SETUP  = 4'd1;
    localparam logic [3:0] S_W_STROBE = 4'd2;
    localparam logic [3:0] S_W_HOLD   = 4'd3;
    localparam logic [3:0] S_R_SETUP  = 4'd4;
    localparam logic [3:0] S_R_STROBE = 4'd5;
`ifdef PIC_HOST_INTA_EN
    localparam logic [3:0] S_A_PULSE1 = 4'd6;
    localparam logic [3:0] S_A_GAP    = 4'd7;
    localparam logic [3:0] S_A_PULSE2 = 4'd8;
`endif
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [1:0] K_INIT = 2'd0;
    localparam logic [1:0] K_OCW  = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;
`ifdef PIC_HOST_INTA_EN
    localparam logic [1:0] K_ACK  = 2'd3;
`endif

    logic [3:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_kind;
    logic [1:0]    r_step;
    logic [7:0]    r_icw2, r_icw3, r_icw4;
    logic          r_sngl, r_ic4;
    logic          r_a0;
    logic [7:0]    r_data;
    logic          r_init_done;
    logic [7:0]    r_rd_data;

    logic          w_more;
    logic [1:0]    w_next_step;
    logic [7:0]    w_next_word;

    // Which ICW follows the one just written; ICW3 is skipped in single mode, ICW4 unless IC4.
    always_comb begin
        w_more      = 1'b0;
        w_next_step = r_step;
        w_next_word = r_icw2;
        case (r_step)
            2'd0: begin
                w_more      = 1'b1;
                w_next_step = 2'd1;
                w_next_word = r_icw2;
            end
            2'd1: begin
                if (!r_sngl) begin
                    w_more      = 1'b1;
                    w_next_step = 2'd2;
                    w_next_word = r_icw3;
                end else if (r_ic4) begin
                    w_more      = 1'b1;
                    w_next_step = 2'd3;
                    w_next_word = r_icw4;
                end
            end
            2'd2: begin
                if (r_ic4) begin
                    w_more      = 1'b1;
                    w_next_step = 2'd3;
                    w_next_word = r_icw4;
                end
            end
            default: ;
        endcase
    end

`ifdef PIC_HOST_INTA_EN
    logic       r_int_m, r_int_s;
    logic [7:0] r_vector;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int_m <= 1'b0;
            r_int_s <= 1'b0;
        end else begin
            r_int_m <= int_in;
            r_int_s <= r_int_m;
        end
    end
`else
    logic w_unused_int;
    assign w_unused_int = int_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_kind      <= K_INIT;
            r_step      <= 2'd0;
            r_icw2      <= 8'h00;
            r_icw3      <= 8'h00;
            r_icw4      <= 8'h00;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_a0        <= 1'b0;
            r_data      <= 8'h00;
            r_init_done <= 1'b0;
            r_rd_data   <= 8'h00;
`ifdef PIC_HOST_INTA_EN
            r_vector    <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_init) begin
                        r_icw2      <= icw2;
                        r_icw3      <= icw3;
                        r_icw4      <= icw4;
                        r_sngl      <= icw1[1];
                        r_ic4       <= icw1[0];
                        r_init_done <= 1'b0;
                        r_step      <= 2'd0;
                        r_kind      <= K_INIT;
                        r_a0        <= 1'b0;
                        r_data      <= icw1 | 8'h10;
                        r_state     <= S_W_SETUP;
                    end
`ifdef PIC_HOST_INTA_EN
                    else if (r_int_s && r_init_done) begin
                        r_kind  <= K_ACK;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_A_PULSE1;
                    end
`endif
                    else if (ocw_req) begin
                        r_kind  <= K_OCW;
                        r_a0    <= ocw_a0;
                        r_data  <= ocw_data;
                        r_state <= S_W_SETUP;
                    end else if (rd_req) begin
                        r_kind  <= K_RD;
                        r_a0    <= 1'b0;
                        r_state <= S_R_SETUP;
                    end
                end
                S_W_SETUP: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_W_STROBE;
                end
                S_W_STROBE: begin
                    if (r_cnt == '0) r_state <= S_W_HOLD;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_W_HOLD: begin
                    if (r_kind == K_INIT && w_more) begin
                        r_step  <= w_next_step;
                        r_a0    <= 1'b1;
                        r_data  <= w_next_word;
                        r_state <= S_W_SETUP;
                    end else begin
                        if (r_kind == K_INIT) r_init_done <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_R_SETUP: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_R_STROBE;
                end
                S_R_STROBE: begin
                    if (r_cnt == '0) begin
                        r_rd_data <= data_in;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef PIC_HOST_INTA_EN
                S_A_PULSE1: begin
                    if (r_cnt == '0) r_state <= S_A_GAP;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_A_GAP: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_A_PULSE2;
                end
                S_A_PULSE2: begin
                    if (r_cnt == '0) begin
                        r_vector <= data_in;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: strobes decode straight from the state register so an async reset releases them at once.
    assign wr_n      = (r_state != S_W_STROBE);
    assign rd_n      = (r_state != S_R_STROBE);
    assign data_oe   = (r_state == S_W_SETUP) || (r_state == S_W_STROBE) || (r_state == S_W_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign a0        = r_a0;
    assign data_out  = r_data;
    assign init_done = r_init_done;
    assign rd_data   = r_rd_data;
    assign ocw_done  = (r_state == S_DONE) && (r_kind == K_OCW);
    assign rd_valid  = (r_state == S_DONE) && (r_kind == K_RD);

`ifdef PIC_HOST_INTA_EN
    assign inta_n       = !((r_state == S_A_PULSE1) || (r_state == S_A_PULSE2));
    assign vector       = r_vector;
    assign vector_valid = (r_state == S_DONE) && (r_kind == K_ACK);
`else
    assign inta_n       = 1'b1;
    assign vector       = 8'h00;
    assign vector_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pic_host_driver.sv
// Self-checking bench for pic_host_driver: transaction-level expected traces compared cycle by cycle.
// Covers the acknowledge path when PIC_HOST_INTA_EN is defined, its absence otherwise.

module tb_pic_host_driver;

    localparam int S    = 2;
    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       reset, start_init, ocw_req, ocw_a0, rd_req, int_in;
    logic [7:0] icw1, icw2, icw3, icw4, ocw_data, data_in;
    logic       wr_n, rd_n, inta_n, a0, data_oe, busy, init_done;
    logic       ocw_done, rd_valid, vector_valid;
    logic [7:0] data_out, rd_data, vector;

    pic_host_driver #(.STROBE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start_init(start_init),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw_req(ocw_req), .ocw_a0(ocw_a0), .ocw_data(ocw_data),
        .rd_req(rd_req), .int_in(int_in), .data_in(data_in),
        .wr_n(wr_n), .rd_n(rd_n), .inta_n(inta_n), .a0(a0),
        .data_out(data_out), .data_oe(data_oe), .busy(busy),
        .init_done(init_done), .ocw_done(ocw_done), .rd_valid(rd_valid),
        .vector_valid(vector_valid), .rd_data(rd_data), .vector(vector)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected per-cycle trace, cycle 1 = first cycle after the request-sampling edge.
    logic       e_wr [MAXC], e_rd [MAXC], e_inta [MAXC], e_busy [MAXC], e_oe [MAXC];
    logic       e_idone [MAXC], e_ocwd [MAXC], e_rdv [MAXC], e_vv [MAXC];
    logic       e_a0c [MAXC], e_a0 [MAXC];
    logic [7:0] e_do [MAXC], e_rdd [MAXC], e_vec [MAXC], e_capv [MAXC];
    int         e_capk [MAXC];
    int         tc;
    logic       m_idone;
    logic [7:0] m_rd, m_vec, p_rd, p_vec;

    task automatic chk1(input string scn, input string sig, input int c, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s cyc=%0d observed=%b expected=%b", scn, sig, c, obs, exp);
        end
    endtask

    task automatic chk8(input string scn, input string sig, input int c, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s cyc=%0d observed=%h expected=%h", scn, sig, c, obs, exp);
        end
    endtask

    task automatic clear_trace();
        for (int c = 0; c < MAXC; c++) begin
            e_wr[c] = 1'b1; e_rd[c] = 1'b1; e_inta[c] = 1'b1; e_busy[c] = 1'b0; e_oe[c] = 1'b0;
            e_idone[c] = m_idone; e_ocwd[c] = 1'b0; e_rdv[c] = 1'b0; e_vv[c] = 1'b0;
            e_a0c[c] = 1'b0; e_a0[c] = 1'b0; e_do[c] = 8'h00; e_capk[c] = 0; e_capv[c] = 8'h00;
        end
        p_rd = m_rd;
        p_vec = m_vec;
        tc = 1;
    endtask

    task automatic wcyc(input logic w, input logic a, input logic [7:0] d);
        e_busy[tc] = 1'b1; e_wr[tc] = w; e_oe[tc] = 1'b1;
        e_a0c[tc] = 1'b1; e_a0[tc] = a; e_do[tc] = d; e_idone[tc] = m_idone;
        tc++;
    endtask

    task automatic add_write(input logic a, input logic [7:0] d);
        wcyc(1'b1, a, d);
        repeat (S) wcyc(1'b0, a, d);
        wcyc(1'b1, a, d);
    endtask

    task automatic rcyc(input logic r);
        e_busy[tc] = 1'b1; e_rd[tc] = r; e_a0c[tc] = 1'b1; e_a0[tc] = 1'b0; e_idone[tc] = m_idone;
        tc++;
    endtask

    task automatic add_read(input logic [7:0] v);
        rcyc(1'b1);
        repeat (S) rcyc(1'b0);
        e_capk[tc-1] = 1;
        e_capv[tc-1] = v;
        m_rd = v;
    endtask

    task automatic acyc(input logic i);
        e_busy[tc] = 1'b1; e_inta[tc] = i; e_idone[tc] = m_idone;
        tc++;
    endtask

    task automatic add_ack(input logic [7:0] v);
        repeat (S) acyc(1'b0);
        acyc(1'b1);
        repeat (S) acyc(1'b0);
        e_capk[tc-1] = 2;
        e_capv[tc-1] = v;
        m_vec = v;
    endtask

    // k: 0 init, 1 ocw, 2 read, 3 ack
    task automatic add_done(input int k);
        if (k == 0) m_idone = 1'b1;
        e_busy[tc] = 1'b1; e_idone[tc] = m_idone;
        e_ocwd[tc] = (k == 1); e_rdv[tc] = (k == 2); e_vv[tc] = (k == 3);
        tc++;
    endtask

    task automatic add_idle();
        e_idone[tc] = m_idone;
        tc++;
    endtask

    task automatic add_init(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3, input logic [7:0] w4);
        m_idone = 1'b0;
        add_write(1'b0, w1 | 8'h10);
        add_write(1'b1, w2);
        if (!w1[1]) add_write(1'b1, w3);
        if (w1[0])  add_write(1'b1, w4);
        add_done(0);
    endtask

    task automatic finish_trace();
        logic [7:0] r, v;
        for (int c = tc; c < MAXC; c++) e_idone[c] = m_idone;
        r = p_rd;
        v = p_vec;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0 && e_capk[c-1] == 1) r = e_capv[c-1];
            if (c > 0 && e_capk[c-1] == 2) v = e_capv[c-1];
            e_rdd[c] = r;
            e_vec[c] = v;
        end
    endtask

    task automatic run_scn(input string scn, input int ncyc);
        logic [7:0] junk;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk1(scn, "wr_n", c, wr_n, e_wr[c]);
            chk1(scn, "rd_n", c, rd_n, e_rd[c]);
            chk1(scn, "inta_n", c, inta_n, e_inta[c]);
            chk1(scn, "busy", c, busy, e_busy[c]);
            chk1(scn, "data_oe", c, data_oe, e_oe[c]);
            chk1(scn, "init_done", c, init_done, e_idone[c]);
            chk1(scn, "ocw_done", c, ocw_done, e_ocwd[c]);
            chk1(scn, "rd_valid", c, rd_valid, e_rdv[c]);
            chk1(scn, "vector_valid", c, vector_valid, e_vv[c]);
            if (e_a0c[c]) chk1(scn, "a0", c, a0, e_a0[c]);
            if (e_oe[c])  chk8(scn, "data_out", c, data_out, e_do[c]);
            chk8(scn, "rd_data", c, rd_data, e_rdd[c]);
            chk8(scn, "vector", c, vector, e_vec[c]);
            if (ocw_done) ocw_req = 1'b0;
            if (rd_valid) rd_req = 1'b0;
            if (init_done && busy) start_init = 1'b0;
            if (c == 1) int_in = 1'b0;
            if (e_capk[c] != 0) begin
                data_in = e_capv[c];
            end else begin
                junk = 8'($urandom);
                if (junk == m_rd || junk == m_vec) junk = junk ^ 8'h5A;
                data_in = junk;
            end
        end
    endtask

    task automatic settle(input string scn);
        int k;
        start_init = 1'b0; ocw_req = 1'b0; rd_req = 1'b0; int_in = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk1(scn, "settle_busy", k, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic build_ops(input logic di, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input logic [7:0] w4,
                             input logic dw, input logic oa, input logic [7:0] od,
                             input logic dr, input logic [7:0] rv);
        clear_trace();
        if (di) add_init(w1, w2, w3, w4);
        if (dw) begin
            if (tc > 1) add_idle();
            add_write(oa, od);
            add_done(1);
        end
        if (dr) begin
            if (tc > 1) add_idle();
            add_read(rv);
            add_done(2);
        end
        finish_trace();
        icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4;
        ocw_a0 = oa; ocw_data = od;
        start_init = di; ocw_req = dw; rd_req = dr;
    endtask

    initial begin
        logic [7:0] w1, w2, w3, w4, od, rv;
        logic [2:0] sel;

        reset = 1'b0; start_init = 1'b0; ocw_req = 1'b0; rd_req = 1'b0; int_in = 1'b0;
        ocw_a0 = 1'b0; icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
        ocw_data = 8'h00; data_in = 8'h00;
        m_idone = 1'b0; m_rd = 8'h00; m_vec = 8'h00;
        #1 reset = 1'b1;
        #1;
        chk1("reset", "wr_n", 0, wr_n, 1'b1);
        chk1("reset", "rd_n", 0, rd_n, 1'b1);
        chk1("reset", "inta_n", 0, inta_n, 1'b1);
        chk1("reset", "busy", 0, busy, 1'b0);
        chk1("reset", "data_oe", 0, data_oe, 1'b0);
        chk1("reset", "a0", 0, a0, 1'b0);
        chk1("reset", "init_done", 0, init_done, 1'b0);
        chk1("reset", "ocw_done", 0, ocw_done, 1'b0);
        chk1("reset", "rd_valid", 0, rd_valid, 1'b0);
        chk1("reset", "vector_valid", 0, vector_valid, 1'b0);
        chk8("reset", "data_out", 0, data_out, 8'h00);
        chk8("reset", "rd_data", 0, rd_data, 8'h00);
        chk8("reset", "vector", 0, vector, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full init: four writes, init_done at cycle 17
        build_ops(1'b1, 8'h11, 8'h20, 8'h04, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        run_scn("init4", tc + 2);
        settle("init4");

        // Single mode without ICW4: two writes, init_done at cycle 9
        build_ops(1'b1, 8'h12, 8'h20, 8'h04, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        run_scn("init2", tc + 2);
        settle("init2");

`ifdef PIC_HOST_INTA_EN
        // int_in rise reaches int_s two edges later; first INTA pulse the cycle after that
        clear_trace();
        tc = 3;
        add_ack(8'h23);
        add_done(3);
        finish_trace();
        int_in = 1'b1;
        run_scn("inta", tc + 2);
        settle("inta");
`else
        clear_trace();
        finish_trace();
        int_in = 1'b1;
        run_scn("inta_off", 12);
        settle("inta_off");
`endif

        build_ops(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFB, 1'b0, 8'h00);
        run_scn("ocw", tc + 2);
        settle("ocw");
        build_ops(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05);
        run_scn("read", tc + 2);
        settle("read");

        // All three requests at once: init, then OCW, then read
        build_ops(1'b1, 8'h13, 8'h48, 8'h02, 8'h01, 1'b1, 1'b0, 8'h6C, 1'b1, 8'hA7);
        run_scn("prio", tc + 2);
        settle("prio");

        // Reset during the first low cycle of the ICW2 strobe
        build_ops(1'b1, 8'h11, 8'h20, 8'h04, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        run_scn("rst_pre", S + 4);
        reset = 1'b1;
        start_init = 1'b0;
        #1;
        chk1("rst_mid", "wr_n", 0, wr_n, 1'b1);
        chk1("rst_mid", "init_done", 0, init_done, 1'b0);
        chk1("rst_mid", "busy", 0, busy, 1'b0);
        chk1("rst_mid", "data_oe", 0, data_oe, 1'b0);
        chk8("rst_mid", "rd_data", 0, rd_data, 8'h00);
        m_idone = 1'b0; m_rd = 8'h00; m_vec = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // int_s must be ignored while init_done is low
        clear_trace();
        finish_trace();
        int_in = 1'b1;
        run_scn("int_noinit", 10);
        settle("int_noinit");

        build_ops(1'b1, 8'h11, 8'h20, 8'h04, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        run_scn("rst_restart", tc + 2);
        settle("rst_restart");

        for (int it = 0; it < 10; it++) begin
            sel = 3'($urandom_range(1, 7));
            w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom); w4 = 8'($urandom);
            od = 8'($urandom); rv = 8'($urandom);
            build_ops(sel[0], w1, w2, w3, w4, sel[1], 1'($urandom), od, sel[2], rv);
            run_scn("rand", tc + 2);
            settle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
